// File: rtl/decode_arbiter.sv
// decode_arbiter: round-robin arbiter for a shared 3-to-8 decoded resource.
// Grants are held until the owner signals Done, drops its request, or the
// hold limit expires; consecutive grants are always separated by one idle cycle.
module decode_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Req,
    input  logic       Done,
    output logic [2:0] Sel,
    output logic       Good,
    output logic [7:0] Grant,
    output logic       Timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    state_t     state;
    logic [2:0] Ptr;
    logic [3:0] HoldCnt;

    logic [2:0] win;
    logic [2:0] idx;
    logic       found;
    logic       rel_normal;
    logic       rel_forced;

    // Round-robin search: first set request at or above Ptr, wrapping 7->0.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = Ptr + 3'(i);
            if (!found && Req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Release conditions while BUSY; a normal release masks a forced one.
    always_comb begin
        rel_normal = Done || !Req[Sel];
        rel_forced = !rel_normal && (HoldCnt == HOLD_LAST);
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            Ptr     <= '0;
            HoldCnt <= '0;
            Sel     <= '0;
            Good    <= 1'b0;
            Grant   <= '0;
            Timeout <= 1'b0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    Timeout <= 1'b0;
                    if (found) begin
                        state   <= BUSY;
                        Sel     <= win;
                        Good    <= 1'b1;
                        Grant   <= 8'd1 << win;
                        HoldCnt <= '0;
                    end else begin
                        state <= IDLE;
                        Good  <= 1'b0;
                        Grant <= '0;
                    end
                end
                BUSY: begin
                    if (rel_normal || rel_forced) begin
                        state   <= GAP;
                        Good    <= 1'b0;
                        Grant   <= '0;
                        Ptr     <= Sel + 3'd1;
                        Timeout <= rel_forced;
                    end else begin
                        HoldCnt <= HoldCnt + 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    Good    <= 1'b0;
                    Grant   <= '0;
                    Timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_arbiter.sv
// Testbench for decode_arbiter: three instances (HOLD_MAX 15, 4, 1) share
// inputs; each is compared every cycle with a behavioural model, plus
// constant-expectation tables and hand sequences for the corner cases.
module tb_decode_arbiter;

    logic       Clk;
    logic       Reset;
    logic [7:0] Req;
    logic       Done;

    logic [2:0] sel15, sel4, sel1;
    logic       good15, good4, good1;
    logic [7:0] grant15, grant4, grant1;
    logic       to15, to4, to1;

    decode_arbiter #(.HOLD_MAX(15)) dut15 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Done(Done),
        .Sel(sel15), .Good(good15), .Grant(grant15), .Timeout(to15)
    );
    decode_arbiter #(.HOLD_MAX(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Done(Done),
        .Sel(sel4), .Good(good4), .Grant(grant4), .Timeout(to4)
    );
    decode_arbiter #(.HOLD_MAX(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Done(Done),
        .Sel(sel1), .Good(good1), .Grant(grant1), .Timeout(to1)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an owner is either present or not; a grant ends when
    // the owner is done, withdraws, or has held it for hold_max cycles.
    int hold_max [3] = '{15, 4, 1};
    bit m_busy   [3];
    int m_owner  [3];
    int m_held   [3];
    int m_ptr    [3];
    int m_sel    [3];
    bit m_to     [3];

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0; m_owner[k] = 0; m_held[k] = 0;
            m_ptr[k] = 0;  m_sel[k] = 0;   m_to[k] = 0;
        end
    endfunction

    function automatic void model_step(input logic [7:0] r, input logic d);
        for (int k = 0; k < 3; k++) begin
            if (m_busy[k]) begin
                bit rel;
                rel = d || !r[m_owner[k]];
                if (rel || (m_held[k] + 1 >= hold_max[k])) begin
                    m_busy[k] = 0;
                    m_ptr[k]  = (m_owner[k] + 1) % 8;
                    m_to[k]   = !rel;
                end else begin
                    m_held[k]++;
                end
            end else begin
                m_to[k] = 0;
                for (int j = 0; j < 8; j++) begin
                    int c;
                    c = (m_ptr[k] + j) % 8;
                    if (!m_busy[k] && r[c]) begin
                        m_busy[k]  = 1;
                        m_owner[k] = c;
                        m_sel[k]   = c;
                        m_held[k]  = 0;
                    end
                end
            end
        end
    endfunction

    task automatic check_inst(input int k, input logic [2:0] s, input logic g,
                              input logic [7:0] gr, input logic t);
        int exp_grant;
        exp_grant = m_busy[k] ? (1 << m_owner[k]) : 0;
        check($sformatf("m%0d_sel", hold_max[k]), s, m_sel[k]);
        check($sformatf("m%0d_good", hold_max[k]), g, m_busy[k]);
        check($sformatf("m%0d_grant", hold_max[k]), gr, exp_grant);
        check($sformatf("m%0d_timeout", hold_max[k]), t, m_to[k]);
        check($sformatf("m%0d_onehot", hold_max[k]), $countones(gr) <= 1, 1);
    endtask

    task automatic check_all();
        check_inst(0, sel15, good15, grant15, to15);
        check_inst(1, sel4, good4, grant4, to4);
        check_inst(2, sel1, good1, grant1, to1);
    endtask

    // Called at posedge+1: apply inputs, take one edge, compare at posedge+1.
    task automatic run_cycle(input logic [7:0] r, input logic d);
        Req  = r;
        Done = d;
        @(posedge Clk);
        if (Reset) model_reset();
        else model_step(r, d);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse, checked before the next clock edge.
    task automatic do_reset();
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("async_rst_good", good15, 0);
        check("async_rst_grant", grant15, 0);
        @(posedge Clk);
        #1;
        check_all();
        Reset = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] req;
        logic       done;
        logic [2:0] sel;
        logic       good;
        logic [7:0] grant;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, logic [7:0] r, logic d, logic [2:0] s,
                                logic g, logic [7:0] gr, logic t);
        vec_t v;
        v.rst = rst; v.req = r; v.done = d; v.sel = s;
        v.good = g; v.grant = gr; v.to = t;
        vecs.push_back(v);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Req   = '0;
        Done  = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;
        check_all();
        Reset = 1'b0;

        // Held single request, Done after 3 grant cycles, then re-grant.
        add(1, 8'h00, 0, 0, 0, 8'h00, 0);
        add(0, 8'h01, 0, 0, 1, 8'h01, 0);
        add(0, 8'h01, 0, 0, 1, 8'h01, 0);
        add(0, 8'h01, 0, 0, 1, 8'h01, 0);
        add(0, 8'h01, 1, 0, 0, 8'h00, 0);
        add(0, 8'h01, 0, 0, 1, 8'h01, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, 0);
        // Two requesters alternate 0,7,0,7 with a gap between grants.
        add(1, 8'h00, 0, 0, 0, 8'h00, 0);
        add(0, 8'h81, 0, 0, 1, 8'h01, 0);
        add(0, 8'h81, 1, 0, 0, 8'h00, 0);
        add(0, 8'h81, 0, 7, 1, 8'h80, 0);
        add(0, 8'h81, 1, 7, 0, 8'h00, 0);
        add(0, 8'h81, 0, 0, 1, 8'h01, 0);
        add(0, 8'h81, 1, 0, 0, 8'h00, 0);
        add(0, 8'h81, 0, 7, 1, 8'h80, 0);
        add(0, 8'h00, 0, 7, 0, 8'h00, 0);
        add(0, 8'h00, 0, 7, 0, 8'h00, 0);
        // Owner 5 withdraws; pointer moves to 6 so 4 wins after the gap.
        add(1, 8'h00, 0, 0, 0, 8'h00, 0);
        add(0, 8'h20, 0, 5, 1, 8'h20, 0);
        add(0, 8'h30, 0, 5, 1, 8'h20, 0);
        add(0, 8'h10, 0, 5, 0, 8'h00, 0);
        add(0, 8'h10, 0, 4, 1, 8'h10, 0);
        add(0, 8'h00, 0, 4, 0, 8'h00, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            else run_cycle(vecs[i].req, vecs[i].done);
            check($sformatf("vec%0d_sel", i), sel15, vecs[i].sel);
            check($sformatf("vec%0d_good", i), good15, vecs[i].good);
            check($sformatf("vec%0d_grant", i), grant15, vecs[i].grant);
            check($sformatf("vec%0d_timeout", i), to15, vecs[i].to);
        end

        // HOLD_MAX=4: four grant cycles, forced release with Timeout, re-grant.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_cycle(8'h04, 0);
            check("h4_hold_good", good4, 1);
            check("h4_hold_grant", grant4, 8'h04);
            check("h4_hold_to", to4, 0);
        end
        run_cycle(8'h04, 0);
        check("h4_force_good", good4, 0);
        check("h4_force_to", to4, 1);
        check("h4_force_sel", sel4, 2);
        run_cycle(8'h04, 0);
        check("h4_regrant_good", good4, 1);
        check("h4_regrant_sel", sel4, 2);
        check("h4_regrant_to", to4, 0);
        // Done coincides with the last permitted hold cycle: no Timeout.
        for (int i = 0; i < 3; i++) run_cycle(8'h04, 0);
        check("h4_last_good", good4, 1);
        run_cycle(8'h04, 1);
        check("h4_done_edge_good", good4, 0);
        check("h4_done_edge_to", to4, 0);

        // Async reset mid-grant on index 3 with Ptr moved away from 0.
        do_reset();
        run_cycle(8'h01, 0);
        run_cycle(8'h01, 1);
        run_cycle(8'h08, 0);
        check("rst_pre_grant", grant15, 8'h08);
        do_reset();
        run_cycle(8'h03, 0);
        check("rst_post_sel", sel15, 0);
        check("rst_post_grant", grant15, 8'h01);

        // Randomized traffic against the model, with occasional async resets.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            logic d;
            r = 8'($urandom);
            if ($urandom_range(3, 0) == 0) r = r & 8'($urandom);
            if ($urandom_range(7, 0) == 0) r = '0;
            d = ($urandom_range(4, 0) == 0);
            run_cycle(r, d);
            if ($urandom_range(99, 0) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
